// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ADDR_W          : width of the PC / jump target.
//   MDU_TIMEOUT_DEF : default abort limit (in MDU_WAIT cycles) for a multi-cycle op.
//   ST_*            : controller state encodings.
package pipe_ctrl_pkg;

    localparam int ADDR_W          = 32;
    localparam int MDU_TIMEOUT_DEF = 63;

    localparam logic [1:0] ST_RUN         = 2'd0;
    localparam logic [1:0] ST_LOAD_BUBBLE = 2'd1;
    localparam logic [1:0] ST_MDU_WAIT    = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT    = 2'd3;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Watchdog for multi-cycle (MDU) operations.
//   clk, arst  : clock, asynchronous active-high reset.
//   clr_i      : restart the count (new MDU op entering its wait).
//   en_i       : one more cycle spent waiting for the MDU result.
//   expired_o  : combinational; high in the wait cycle that brings the
//                count to TIMEOUT, so the controller can abort in that cycle.
module pipe_ctrl_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = MDU_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic arst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    // One spare bit so the count can never wrap before it reaches TIMEOUT.
    localparam int CW = $clog2(TIMEOUT + 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign expired_o = en_i && ((int'(cnt_q) + 1) >= TIMEOUT);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / stall controller.
//   clk, arst                      : clock, asynchronous active-high reset.
//   jump_flag_i, jump_addr_i       : EX-stage taken branch/jump and its target.
//   hold_risk_i                    : EX-stage load-use hazard.
//   mdu_start_i, mdu_done_i        : multi-cycle op in EX / its result valid.
//   mem_busy_i                     : data memory not ready.
//   stall_*_o                      : hold the named pipeline register.
//   flush_*_o                      : load a bubble into the named register.
//   jump_flag_o, jump_addr_o       : PC redirect (address is 0 when no redirect).
//   err_o                          : sticky MDU timeout, cleared only by reset.
//   stall_cnt_o                    : wrapping count of cycles with stall_pc_o=1.
// All control outputs are combinational from state and inputs so they act in
// the cycle the hazard is seen.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_risk_i,
    input  logic              mdu_start_i,
    input  logic              mdu_done_i,
    input  logic              mem_busy_i,
    output logic              stall_pc_o,
    output logic              stall_if_id_o,
    output logic              stall_id_ex_o,
    output logic              stall_ex_mem_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_expired;

    pipe_ctrl_wdog #(
        .TIMEOUT (MDU_TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .arst      (arst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        stall_pc_o     = 1'b0;
        stall_if_id_o  = 1'b0;
        stall_id_ex_o  = 1'b0;
        stall_ex_mem_o = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        jump_flag_o    = 1'b0;
        jump_addr_o    = '0;
        state_d        = ST_RUN;
        wd_clr         = 1'b0;
        wd_en          = 1'b0;

        // Outputs are forced quiet while reset is held, whatever the inputs.
        if (!arst) begin
            if (state_q == ST_MDU_WAIT) begin
                // Done releases the stalls; a jump in this cycle is ignored.
                if (!mdu_done_i) begin
                    stall_pc_o     = 1'b1;
                    stall_if_id_o  = 1'b1;
                    stall_id_ex_o  = 1'b1;
                    stall_ex_mem_o = mem_busy_i;
                    wd_en          = 1'b1;
                    state_d        = wd_expired ? ST_RUN : ST_MDU_WAIT;
                end
            end else if (mem_busy_i) begin
                // Same decision from RUN, LOAD_BUBBLE or a continuing MEM_WAIT.
                stall_pc_o     = 1'b1;
                stall_if_id_o  = 1'b1;
                stall_id_ex_o  = 1'b1;
                stall_ex_mem_o = 1'b1;
                state_d        = ST_MEM_WAIT;
            end else if (mdu_start_i && !mdu_done_i) begin
                stall_pc_o    = 1'b1;
                stall_if_id_o = 1'b1;
                stall_id_ex_o = 1'b1;
                wd_clr        = 1'b1;
                state_d       = ST_MDU_WAIT;
            end else if (jump_flag_i) begin
                jump_flag_o   = 1'b1;
                jump_addr_o   = jump_addr_i;
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
            end else if (hold_risk_i && (state_q != ST_LOAD_BUBBLE)) begin
                // The bubble cycle ignores the hazard so the stalled load can
                // retire; otherwise the same hazard would stall forever.
                stall_pc_o    = 1'b1;
                stall_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
                state_d       = ST_LOAD_BUBBLE;
            end
        end
    end

    always_comb begin
        err_d       = err_q | wd_expired;
        stall_cnt_d = stall_cnt_q;
        if (stall_pc_o) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_RUN;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int TMO  = 4;
    localparam int CW   = 4;
    localparam int NRND = 3000;

    typedef struct packed {
        logic        jump;
        logic [31:0] addr;
        logic        hold;
        logic        start;
        logic        done;
        logic        busy;
    } in_t;

    // flag order: stall pc, if_id, id_ex, ex_mem, flush if_id, id_ex, jump
    typedef struct packed {
        logic [6:0]  flags;
        logic [31:0] jaddr;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_ALL4 = 7'b1111000;
    localparam logic [6:0] F_MDU3 = 7'b1110000;
    localparam logic [6:0] F_JMP  = 7'b0000111;
    localparam logic [6:0] F_HOLD = 7'b1100010;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_risk_i = 1'b0;
    logic        mdu_start_i = 1'b0;
    logic        mdu_done_i = 1'b0;
    logic        mem_busy_i = 1'b0;
    logic        stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o;
    logic        flush_if_id_o, flush_id_ex_o, jump_flag_o, err_o;
    logic [31:0] jump_addr_o;
    logic [CW-1:0] stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the pipeline is currently waiting on.
    localparam int M_RUN = 0, M_BUBBLE = 1, M_MEM = 2, M_MDU = 3;
    int m_mode = M_RUN;
    int m_wait = 0;
    bit m_err  = 1'b0;
    int m_cnt  = 0;

    pipe_ctrl #(.MDU_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk            (clk),
        .arst           (arst),
        .jump_flag_i    (jump_flag_i),
        .jump_addr_i    (jump_addr_i),
        .hold_risk_i    (hold_risk_i),
        .mdu_start_i    (mdu_start_i),
        .mdu_done_i     (mdu_done_i),
        .mem_busy_i     (mem_busy_i),
        .stall_pc_o     (stall_pc_o),
        .stall_if_id_o  (stall_if_id_o),
        .stall_id_ex_o  (stall_id_ex_o),
        .stall_ex_mem_o (stall_ex_mem_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .jump_flag_o    (jump_flag_o),
        .jump_addr_o    (jump_addr_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(logic j, logic [31:0] a, logic h, logic s, logic d, logic b);
        in_t r;
        r.jump = j; r.addr = a; r.hold = h; r.start = s; r.done = d; r.busy = b;
        return r;
    endfunction

    function automatic out_t mk_out(logic [6:0] f, logic [31:0] a);
        out_t r;
        r.flags = f; r.jaddr = a;
        return r;
    endfunction

    task automatic drive(input in_t i);
        jump_flag_i = i.jump;
        jump_addr_i = i.addr;
        hold_risk_i = i.hold;
        mdu_start_i = i.start;
        mdu_done_i  = i.done;
        mem_busy_i  = i.busy;
    endtask

    task automatic check(input string name, input out_t eo, input logic eerr,
                         input logic [CW-1:0] ecnt, input bit verbose);
        out_t ao;
        ao = {stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o,
              flush_if_id_o, flush_id_ex_o, jump_flag_o, jump_addr_o};
        n_tests++;
        if (ao !== eo || err_o !== eerr || stall_cnt_o !== ecnt) begin
            n_fail++;
            $display("FAIL %s: got flags=%b addr=%h err=%b cnt=%0d, want flags=%b addr=%h err=%b cnt=%0d",
                     name, ao.flags, ao.jaddr, err_o, stall_cnt_o, eo.flags, eo.jaddr, eerr, ecnt);
        end else if (verbose) begin
            $display("[TB] ok %s flags=%b addr=%h err=%b cnt=%0d", name, ao.flags, ao.jaddr, err_o, stall_cnt_o);
        end
    endtask

    // One clock cycle: drive away from the active edge, check 1 time unit later.
    task automatic apply(input string name, input in_t i, input out_t eo,
                         input logic eerr, input logic [CW-1:0] ecnt, input bit verbose);
        @(negedge clk);
        drive(i);
        #1;
        check(name, eo, eerr, ecnt, verbose);
    endtask

    task automatic do_reset(input bit verbose);
        @(negedge clk);
        arst = 1'b1;
        drive(mk_in(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1));
        #1;
        check("reset", mk_out(F_NONE, 32'h0), 1'b0, '0, verbose);
        drive(mk_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1;
        arst = 1'b0;
        m_mode = M_RUN; m_wait = 0; m_err = 1'b0; m_cnt = 0;
    endtask

    // Behavioural rules: what must happen this cycle given what we wait on.
    task automatic model_step(input in_t i, output out_t o);
        int nmode;
        o = '0;
        nmode = M_RUN;
        if (m_mode == M_MDU) begin
            if (!i.done) begin
                o.flags = {3'b111, i.busy, 3'b000};
                if (m_wait + 1 >= TMO) begin
                    m_err = 1'b1;
                end else begin
                    m_wait = m_wait + 1;
                    nmode  = M_MDU;
                end
            end
        end else if (i.busy) begin
            o.flags = F_ALL4;
            nmode   = M_MEM;
        end else if (i.start && !i.done) begin
            o.flags = F_MDU3;
            m_wait  = 0;
            nmode   = M_MDU;
        end else if (i.jump) begin
            o.flags = F_JMP;
            o.jaddr = i.addr;
        end else if (i.hold && m_mode != M_BUBBLE) begin
            o.flags = F_HOLD;
            nmode   = M_BUBBLE;
        end
        if (o.flags[6]) m_cnt = (m_cnt + 1) % (1 << CW);
        m_mode = nmode;
    endtask

    initial begin
        vec_t tbl[11];
        in_t  r;
        out_t eo;
        logic e_err;
        logic [CW-1:0] e_cnt;

        tbl[0]  = '{"idle",         mk_in(0, 32'h0,        0, 0, 0, 0), mk_out(F_NONE, 32'h0)};
        tbl[1]  = '{"mem_busy",     mk_in(0, 32'h0,        0, 0, 0, 1), mk_out(F_ALL4, 32'h0)};
        tbl[2]  = '{"busy_prio",    mk_in(1, 32'h1234,     1, 1, 0, 1), mk_out(F_ALL4, 32'h0)};
        tbl[3]  = '{"mdu_start",    mk_in(0, 32'h0,        0, 1, 0, 0), mk_out(F_MDU3, 32'h0)};
        tbl[4]  = '{"mdu_same_jmp", mk_in(1, 32'h100,      0, 1, 1, 0), mk_out(F_JMP,  32'h100)};
        tbl[5]  = '{"mdu_same_hold",mk_in(0, 32'h0,        1, 1, 1, 0), mk_out(F_HOLD, 32'h0)};
        tbl[6]  = '{"jump",         mk_in(1, 32'h100,      0, 0, 0, 0), mk_out(F_JMP,  32'h100)};
        tbl[7]  = '{"jump_prio",    mk_in(1, 32'hCAFE_0004,1, 0, 0, 0), mk_out(F_JMP,  32'hCAFE_0004)};
        tbl[8]  = '{"hold",         mk_in(0, 32'h0,        1, 0, 0, 0), mk_out(F_HOLD, 32'h0)};
        tbl[9]  = '{"addr_masked",  mk_in(0, 32'hDEAD_BEEF,0, 0, 0, 0), mk_out(F_NONE, 32'h0)};
        tbl[10] = '{"mdu_over_jmp", mk_in(1, 32'h44,       0, 1, 0, 0), mk_out(F_MDU3, 32'h0)};

        for (int k = 0; k < 11; k++) begin
            do_reset(1'b0);
            apply(tbl[k].name, tbl[k].i, tbl[k].o, 1'b0, '0, 1'b1);
        end

        // Load-use: second hazard cycle is masked by the bubble.
        do_reset(1'b1);
        apply("lu_c1", mk_in(0, 0, 1, 0, 0, 0), mk_out(F_HOLD, 0), 0, 4'd0, 1);
        apply("lu_c2", mk_in(0, 0, 1, 0, 0, 0), mk_out(F_NONE, 0), 0, 4'd1, 1);
        apply("lu_end", mk_in(0, 0, 0, 0, 0, 0), mk_out(F_NONE, 0), 0, 4'd1, 1);

        // Memory wait, released by a jump.
        do_reset(1'b0);
        for (int k = 0; k < 3; k++)
            apply("mem_hold", mk_in(0, 0, 0, 0, 0, 1), mk_out(F_ALL4, 0), 0, CW'(k), 1);
        apply("mem_rel_jmp", mk_in(1, 32'h40, 0, 0, 0, 0), mk_out(F_JMP, 32'h40), 0, 4'd3, 1);
        apply("mem_end", mk_in(0, 0, 0, 0, 0, 0), mk_out(F_NONE, 0), 0, 4'd3, 1);

        // MDU completes before timeout; memory stall during the wait.
        do_reset(1'b0);
        apply("mdu_c0", mk_in(0, 0, 0, 1, 0, 0), mk_out(F_MDU3, 0), 0, 4'd0, 1);
        apply("mdu_w1", mk_in(0, 0, 0, 1, 0, 0), mk_out(F_MDU3, 0), 0, 4'd1, 1);
        apply("mdu_w2_busy", mk_in(0, 0, 0, 1, 0, 1), mk_out(F_ALL4, 0), 0, 4'd2, 1);
        apply("mdu_w3", mk_in(0, 0, 0, 1, 0, 0), mk_out(F_MDU3, 0), 0, 4'd3, 1);
        apply("mdu_done", mk_in(1, 32'h80, 0, 1, 1, 0), mk_out(F_NONE, 0), 0, 4'd4, 1);
        apply("mdu_end", mk_in(0, 0, 0, 0, 0, 0), mk_out(F_NONE, 0), 0, 4'd4, 1);

        // Timeout: 4 wait cycles without done.
        do_reset(1'b0);
        apply("tmo_c0", mk_in(0, 0, 0, 1, 0, 0), mk_out(F_MDU3, 0), 0, 4'd0, 1);
        for (int k = 1; k <= 4; k++)
            apply("tmo_wait", mk_in(0, 0, 0, 1, 0, 0), mk_out(F_MDU3, 0), 0, CW'(k), 1);
        apply("tmo_run", mk_in(0, 0, 0, 0, 0, 0), mk_out(F_NONE, 0), 1, 4'd5, 1);
        apply("tmo_sticky", mk_in(1, 32'h8, 0, 0, 0, 0), mk_out(F_JMP, 32'h8), 1, 4'd5, 1);
        apply("tmo_sticky2", mk_in(0, 0, 0, 0, 0, 0), mk_out(F_NONE, 0), 1, 4'd5, 1);
        do_reset(1'b1);
        apply("tmo_cleared", mk_in(0, 0, 0, 0, 0, 0), mk_out(F_NONE, 0), 0, 4'd0, 1);

        // Reset pulsed in MDU wait cycle 2.
        do_reset(1'b0);
        apply("rst_c0", mk_in(0, 0, 0, 1, 0, 0), mk_out(F_MDU3, 0), 0, 4'd0, 1);
        apply("rst_w1", mk_in(0, 0, 0, 1, 0, 0), mk_out(F_MDU3, 0), 0, 4'd1, 1);
        apply("rst_w2", mk_in(0, 0, 0, 1, 0, 1), mk_out(F_ALL4, 0), 0, 4'd2, 1);
        #1;
        arst = 1'b1;
        #1;
        check("rst_during", mk_out(F_NONE, 0), 0, 4'd0, 1);
        drive(mk_in(0, 0, 0, 0, 0, 0));
        arst = 1'b0;
        apply("rst_after", mk_in(0, 0, 0, 0, 0, 0), mk_out(F_NONE, 0), 0, 4'd0, 1);
        apply("rst_after2", mk_in(0, 0, 1, 0, 0, 0), mk_out(F_HOLD, 0), 0, 4'd0, 1);

        // Randomised run against the reference model.
        do_reset(1'b0);
        for (int k = 0; k < NRND; k++) begin
            if ($urandom_range(199) == 0) do_reset(1'b0);
            r = mk_in($urandom_range(4) == 0, $urandom, $urandom_range(9) < 3,
                      $urandom_range(4) == 0, $urandom_range(9) < 3, $urandom_range(6) == 0);
            e_err = m_err;
            e_cnt = CW'(m_cnt);
            model_step(r, eo);
            apply("rand", r, eo, e_err, e_cnt, 1'b0);
        end
        $display("[TB] random phase: %0d cycles", NRND);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
